// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: state encoding,
// the bubble instruction and the packed control bundle.
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0] ST_HOLD     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;
    localparam logic [1:0] ST_FAULT    = 2'd3;

    // addi x0, x0, 0 -- loaded by the pipeline registers when flushed
    localparam logic [31:0] NOP_BUBBLE = 32'h0000_0013;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
    } ctrl_t;

    // en is {pc, ifid, idex, exmem, memwb}; fl is {ifid_flush, idex_flush}
    function automatic ctrl_t make_ctrl(input logic [4:0] en, input logic [1:0] fl);
        return ctrl_t'({en, fl});
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// stall/flush sequencer (slave).
interface pipe_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
);

    logic [REG_ADDR_W-1:0] ifid_rs1;
    logic [REG_ADDR_W-1:0] ifid_rs2;
    logic [REG_ADDR_W-1:0] idex_rd;
    logic                  idex_mem_read;
    logic                  branch_taken;
    logic                  imem_ready;
    logic                  dmem_req;
    logic                  dmem_ready;

    logic                  pc_en;
    logic                  ifid_en;
    logic                  idex_en;
    logic                  exmem_en;
    logic                  memwb_en;
    logic                  ifid_flush;
    logic                  idex_flush;
    logic                  fault;
    logic [CNT_W-1:0]      stall_count;

    modport master (
        output ifid_rs1, ifid_rs2, idex_rd, idex_mem_read, branch_taken,
               imem_ready, dmem_req, dmem_ready,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, fault, stall_count
    );

    modport slave (
        input  ifid_rs1, ifid_rs2, idex_rd, idex_mem_read, branch_taken,
               imem_ready, dmem_req, dmem_ready,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, fault, stall_count
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use comparator: flags a decode instruction that reads
// the destination of a load still sitting in execute.
module hazard_detect #(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] i_rs1,
    input  logic [REG_ADDR_W-1:0] i_rs2,
    input  logic [REG_ADDR_W-1:0] i_rd,
    input  logic                  i_mem_read,
    output logic                  o_load_use
);

    // x0 is hardwired to zero, so a load targeting it never creates a dependency
    assign o_load_use = i_mem_read && (i_rd != '0) &&
                        ((i_rd == i_rs1) || (i_rd == i_rs2));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline; Mealy controls
// decoded from state and current hazards, state updated on the falling edge.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int HOLD_CYCLES = 4,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               reset,
    pipe_hazard_ctrl_if.slave  hz
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT);

    logic [1:0]        r_state;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0]  r_stall_count;

    logic [1:0]        w_next_state;
    logic              w_load_use;
    logic              w_mem_stall;
    logic              w_stall_edge;
    ctrl_t             w_run_ctrl;
    ctrl_t             w_ctrl;

    hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard_detect (
        .i_rs1      (hz.ifid_rs1),
        .i_rs2      (hz.ifid_rs2),
        .i_rd       (hz.idex_rd),
        .i_mem_read (hz.idex_mem_read),
        .o_load_use (w_load_use)
    );

    assign w_mem_stall = hz.dmem_req && !hz.dmem_ready;

    // A taken branch discards the dependent instruction, so it outranks load-use
    always_comb begin
        w_run_ctrl = make_ctrl(5'b11111, 2'b00);
        if (hz.branch_taken)
            w_run_ctrl = make_ctrl(5'b11111, 2'b11);
        else if (w_load_use)
            w_run_ctrl = make_ctrl(5'b00111, 2'b01);
        else if (!hz.imem_ready)
            w_run_ctrl = make_ctrl(5'b01111, 2'b10);
    end

    always_comb begin
        w_ctrl       = make_ctrl(5'b00000, 2'b00);
        w_next_state = r_state;
        case (r_state)
            ST_HOLD: begin
                w_ctrl = make_ctrl(5'b00000, 2'b11);
                if (r_hold_cnt == HOLD_LAST)
                    w_next_state = ST_RUN;
            end
            ST_RUN: begin
                if (w_mem_stall)
                    w_next_state = ST_MEM_WAIT;
                else
                    w_ctrl = w_run_ctrl;
            end
            ST_MEM_WAIT: begin
                if (hz.dmem_ready) begin
                    w_ctrl       = w_run_ctrl;
                    w_next_state = ST_RUN;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_next_state = ST_FAULT;
                end
            end
            ST_FAULT: w_next_state = ST_FAULT;
            default:  w_next_state = ST_HOLD;
        endcase
    end

    assign w_stall_edge = ((r_state == ST_RUN) || (r_state == ST_MEM_WAIT)) && !w_ctrl.pc_en;

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_HOLD;
            r_hold_cnt    <= '0;
            r_wait_cnt    <= '0;
            r_stall_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_HOLD)
                r_hold_cnt <= r_hold_cnt + 1'b1;
            if ((r_state == ST_RUN) && w_mem_stall) begin
                r_wait_cnt <= WAIT_W'(1);
            end else if (r_state == ST_MEM_WAIT) begin
                if (hz.dmem_ready)
                    r_wait_cnt <= '0;
                else if (r_wait_cnt != WAIT_LAST)
                    r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (w_stall_edge && (r_stall_count != '1))
                r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign hz.pc_en       = w_ctrl.pc_en;
    assign hz.ifid_en     = w_ctrl.ifid_en;
    assign hz.idex_en     = w_ctrl.idex_en;
    assign hz.exmem_en    = w_ctrl.exmem_en;
    assign hz.memwb_en    = w_ctrl.memwb_en;
    assign hz.ifid_flush  = w_ctrl.ifid_flush;
    assign hz.idex_flush  = w_ctrl.idex_flush;
    assign hz.fault       = (r_state == ST_FAULT);
    assign hz.stall_count = r_stall_count;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hold sequence, hazards, memory waits,
// timeout fault and asynchronous reset, checked with immediate assertions.
module tb_pipe_hazard_ctrl;

    localparam logic [6:0] C_HOLD  = 7'b0000011;
    localparam logic [6:0] C_RUN   = 7'b1111100;
    localparam logic [6:0] C_STALL = 7'b0000000;
    localparam logic [6:0] C_BR    = 7'b1111111;
    localparam logic [6:0] C_LU    = 7'b0011101;
    localparam logic [6:0] C_IMW   = 7'b0111110;

    logic clk;
    logic reset;
    int   assertCount = 0;
    int   failCount   = 0;

    pipe_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(32)) hzIf ();

    pipe_hazard_ctrl #(
        .REG_ADDR_W  (5),
        .HOLD_CYCLES (4),
        .MEM_TIMEOUT (8),
        .CNT_W       (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hzIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change just after the rising edge; the falling edge updates state
    task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic memRead,
                                 input logic branch, input logic imemReady,
                                 input logic dmemReq, input logic dmemReady);
        @(posedge clk);
        hzIf.ifid_rs1      = rs1;
        hzIf.ifid_rs2      = rs2;
        hzIf.idex_rd       = rd;
        hzIf.idex_mem_read = memRead;
        hzIf.branch_taken  = branch;
        hzIf.imem_ready    = imemReady;
        hzIf.dmem_req      = dmemReq;
        hzIf.dmem_ready    = dmemReady;
        #1;
    endtask

    task automatic applyIdle();
        applyStimulus(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic checkOutput(input string tag, input logic [6:0] expCtrl,
                               input logic expFault, input logic [31:0] expCount);
        logic [6:0] obsCtrl;
        obsCtrl = {hzIf.pc_en, hzIf.ifid_en, hzIf.idex_en, hzIf.exmem_en,
                   hzIf.memwb_en, hzIf.ifid_flush, hzIf.idex_flush};
        assertCount++;
        assert (obsCtrl === expCtrl) else begin
            failCount++;
            $error("[TB] FAIL %s ctrl: observed %b expected %b", tag, obsCtrl, expCtrl);
        end
        assertCount++;
        assert (hzIf.fault === expFault) else begin
            failCount++;
            $error("[TB] FAIL %s fault: observed %b expected %b", tag, hzIf.fault, expFault);
        end
        assertCount++;
        assert (hzIf.stall_count === expCount) else begin
            failCount++;
            $error("[TB] FAIL %s stall_count: observed %0d expected %0d", tag, hzIf.stall_count, expCount);
        end
    endtask

    initial begin
        reset = 1'b0;
        hzIf.ifid_rs1      = 5'd1;
        hzIf.ifid_rs2      = 5'd2;
        hzIf.idex_rd       = 5'd3;
        hzIf.idex_mem_read = 1'b0;
        hzIf.branch_taken  = 1'b0;
        hzIf.imem_ready    = 1'b1;
        hzIf.dmem_req      = 1'b0;
        hzIf.dmem_ready    = 1'b0;

        $display("[TB] reset and post-reset hold");
        applyIdle();
        checkOutput("in_reset", C_HOLD, 1'b0, 32'd0);
        @(negedge clk);
        #2 reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyIdle();
            checkOutput($sformatf("hold_%0d", i), C_HOLD, 1'b0, 32'd0);
        end
        applyIdle();
        checkOutput("run_after_hold", C_RUN, 1'b0, 32'd0);

        $display("[TB] load-use hazards");
        applyStimulus(5'd5, 5'd2, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("loaduse_rs1", C_LU, 1'b0, 32'd0);
        applyIdle();
        checkOutput("after_loaduse", C_RUN, 1'b0, 32'd1);
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("loaduse_rd0", C_RUN, 1'b0, 32'd1);
        applyStimulus(5'd1, 5'd7, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("loaduse_rs2", C_LU, 1'b0, 32'd1);

        $display("[TB] branch and fetch wait");
        applyStimulus(5'd5, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("branch_over_lu", C_BR, 1'b0, 32'd2);
        applyStimulus(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("imem_wait", C_IMW, 1'b0, 32'd2);
        applyIdle();
        checkOutput("after_imem", C_RUN, 1'b0, 32'd3);

        $display("[TB] data memory wait");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            checkOutput($sformatf("dmem_wait_%0d", i), C_STALL, 1'b0, 32'(3 + i));
        end
        applyStimulus(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("dmem_release", C_RUN, 1'b0, 32'd6);
        applyIdle();
        checkOutput("after_dmem", C_RUN, 1'b0, 32'd6);
        applyStimulus(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("dmem_same_cycle", C_RUN, 1'b0, 32'd6);
        applyIdle();
        checkOutput("no_memwait_entry", C_RUN, 1'b0, 32'd6);

        $display("[TB] branch held across memory wait");
        for (int i = 0; i < 2; i++) begin
            applyStimulus(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
            checkOutput($sformatf("br_memwait_%0d", i), C_STALL, 1'b0, 32'(6 + i));
        end
        applyStimulus(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("br_on_release", C_BR, 1'b0, 32'd8);
        applyIdle();
        checkOutput("after_br_release", C_RUN, 1'b0, 32'd8);

        $display("[TB] data memory timeout");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            checkOutput($sformatf("timeout_wait_%0d", i), C_STALL, 1'b0, 32'(8 + i));
        end
        applyStimulus(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("fault_set", C_STALL, 1'b1, 32'd17);
        applyStimulus(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("fault_sticky", C_STALL, 1'b1, 32'd17);

        $display("[TB] asynchronous reset from fault");
        applyIdle();
        reset = 1'b0;
        #1;
        checkOutput("async_reset", C_HOLD, 1'b0, 32'd0);
        @(negedge clk);
        #2 reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyIdle();
            checkOutput($sformatf("rehold_%0d", i), C_HOLD, 1'b0, 32'd0);
        end
        applyIdle();
        checkOutput("rerun", C_RUN, 1'b0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Drives the enable and bubble-insert (flush) controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB enable-registers.
- Resolves load-use hazards, taken branches, instruction-fetch wait and data-memory wait states.
- Provides a post-reset hold, a data-memory timeout fault and a saturating stall-cycle counter.

Parameters:
- REG_ADDR_W, 5, register-index width.
- HOLD_CYCLES, 4, cycles the pipeline stays frozen and flushed after reset release (≥1).
- MEM_TIMEOUT, 255, maximum consecutive dmem wait cycles before fault (≥2).
- CNT_W, 32, width of stall_count.

Ports:
- clk  in  1  pipeline clock; all state updates on the falling edge, same edge as the pipeline registers.
- reset  in  1  asynchronous, active-low.
- ifid_rs1  in  REG_ADDR_W  rs1 of the instruction in decode.
- ifid_rs2  in  REG_ADDR_W  rs2 of the instruction in decode.
- idex_rd  in  REG_ADDR_W  rd of the instruction in execute.
- idex_mem_read  in  1  the instruction in execute is a load.
- branch_taken  in  1  EX resolved a taken branch/jump.
- imem_ready  in  1  fetch data valid this cycle.
- dmem_req  in  1  MEM stage access active.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register enables.
- ifid_flush, idex_flush  out  1 each  load a NOP bubble into that register.
- fault  out  1  sticky dmem timeout indication.
- stall_count  out  CNT_W  cycles with pc_en=0 while in RUN or MEM_WAIT.

Behaviour:
- States: HOLD, RUN, MEM_WAIT, FAULT. Reset enters HOLD with hold_cnt=0, wait_cnt=0, stall_count=0, fault=0.
- Outputs are Mealy, decoded from state and current inputs, so a stall takes effect in the same cycle.

HOLD:
- All enables 0; ifid_flush=idex_flush=1.
- hold_cnt increments each edge; go to RUN on the edge where hold_cnt==HOLD_CYCLES-1.

RUN, decoded in priority order:
1. dmem_req && !dmem_ready
   - All enables 0, flushes 0.
   - Next state MEM_WAIT with wait_cnt=1.
2. branch_taken
   - All enables 1; ifid_flush=idex_flush=1.
   - Branch overrides any load-use condition, since the dependent instruction is discarded.
3. Load-use: idex_mem_read && idex_rd!=0 && (idex_rd==ifid_rs1 || idex_rd==ifid_rs2)
   - pc_en=0, ifid_en=0, idex_flush=1.
   - idex_en, exmem_en, memwb_en = 1.
4. !imem_ready
   - pc_en=0, ifid_flush=1.
   - All other enables 1.
5. Otherwise all enables 1, flushes 0.

MEM_WAIT:
- While !dmem_ready: outputs as rule 1; wait_cnt increments.
- If wait_cnt==MEM_TIMEOUT with dmem_ready still 0: next state FAULT.
- On dmem_ready=1: outputs evaluated by RUN rules 2–5 in that cycle; next state RUN, wait_cnt cleared.

FAULT:
- All enables 0, flushes 0, fault=1.
- Left only by reset.

stall_count:
- Increments on each edge where state is RUN or MEM_WAIT and pc_en=0.
- Saturates at all-ones; not cleared except by reset.

Boundary conditions:
- Asserting reset mid-operation immediately forces HOLD outputs (asynchronous), whatever the state.
- dmem_ready=1 in the same cycle as the request: no stall, no MEM_WAIT entry.
- branch_taken held during MEM_WAIT is acted on in the cycle the memory completes.
- idex_rd==0 never causes a load-use stall.

Decomposition:
- Shared package holds the state encoding constants (HOLD=2'd0, RUN=2'd1, MEM_WAIT=2'd2, FAULT=2'd3).
- Shared package also holds a NOP-bubble constant (0x00000013) used by the pipeline registers on flush.
- One natural sub-module: hazard_detect, the combinational load-use comparator (rs1/rs2/rd/mem_read → load_use).
- hold_cnt, wait_cnt and stall_count stay in the top module.

Test Plan:
- Reset release, HOLD_CYCLES=4: enables 0 and flushes 1 for exactly 4 falling edges, then all enables 1; stall_count=0.
- Load x5, next instruction uses rs1=5 (idex_mem_read=1, idex_rd=5): one cycle with pc_en=ifid_en=0 and idex_flush=1, then normal; stall_count +1.
- Same as above but idex_rd=0: no stall.
- branch_taken=1 together with a load-use condition: ifid_flush=idex_flush=1, pc_en=1, no stall counted.
- dmem_req=1 with dmem_ready low for 3 cycles: all enables 0 for 3 cycles, release in the 4th cycle; stall_count +3.
- dmem_ready never rises, MEM_TIMEOUT=8: fault=1 after the timeout edge and stays high; asserting reset clears fault and returns to HOLD.
